// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_pkg
// Description : Shared definitions for the TPL DAC DMA FIFO slice; holds the
//               control state encoding used by the FIFO top.
// Revision    : 1.0 - initial release
// ============================================================================
package ad_ip_jesd204_tpl_dac_pkg;

  // Control states of the DMA FIFO; the numeric encoding is part of the
  // register-visible contract and must not be reordered.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2,
    RUN   = 2'd3
  } dac_fifo_state_t;

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_fifo_mem
// Description : Simple dual-port storage, one write port, one synchronous
//               read port. The array has no reset so it maps onto RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_fifo_mem
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: store the beat at the write address.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered read of the addressed word every cycle.
  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_dma_fifo
// Description : DMA-to-TPL-DAC buffering FIFO with prefill, armed start on
//               dac_sync, sticky underflow and flush on enable low.
//               Optional macro TPL_DAC_FIFO_LEVEL_EN adds fifo_level and
//               fifo_peak outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_dma_fifo
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DMA_DATA_WIDTH = 128,
  parameter int ADDR_WIDTH     = 4,
  parameter int PREFILL_LEVEL  = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      dma_valid,
  output logic                      dma_ready,
  input  logic [DMA_DATA_WIDTH-1:0] dma_data,
  input  logic                      dac_valid,
  input  logic                      dac_sync,
  output logic [DMA_DATA_WIDTH-1:0] dac_ddata,
  output logic                      underflow,
  input  logic                      underflow_clr,
`ifdef TPL_DAC_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]       fifo_level,
  output logic [ADDR_WIDTH:0]       fifo_peak,
`endif
  output logic                      running
);

  localparam int                c_depth_int = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth   = (ADDR_WIDTH+1)'(c_depth_int);
  localparam logic [ADDR_WIDTH:0] c_prefill = (ADDR_WIDTH+1)'(PREFILL_LEVEL);

  dac_fifo_state_t           r_state;
  dac_fifo_state_t           w_state_nxt;
  logic [ADDR_WIDTH:0]       r_count;
  logic [ADDR_WIDTH-1:0]     r_wr_ptr;
  logic [ADDR_WIDTH-1:0]     r_rd_ptr;
  logic [ADDR_WIDTH-1:0]     w_rd_ptr_nxt;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_wr;
  logic                      w_rd;
  logic                      w_uflow;
  logic                      w_flush;
  logic [DMA_DATA_WIDTH-1:0] w_mem_q;
  logic [DMA_DATA_WIDTH-1:0] w_head;
  logic [DMA_DATA_WIDTH-1:0] r_byp_data;
  logic                      r_byp_vld;
  logic [DMA_DATA_WIDTH-1:0] r_dac_ddata;
  logic                      r_underflow;

  assign w_flush   = ~enable;
  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign dma_ready = ~w_full & enable;
  assign w_wr      = dma_valid & dma_ready;
  assign w_rd      = (r_state == RUN) & dac_valid & ~w_empty;
  assign w_uflow   = (r_state == RUN) & dac_valid & w_empty;

  // The RAM is read one cycle ahead at the pointer value that will be current
  // after this edge, so the head word is already waiting when a read fires.
  assign w_rd_ptr_nxt = w_flush ? '0 :
                        (w_rd ? r_rd_ptr + ADDR_WIDTH'(1) : r_rd_ptr);

  // A write landing on the prefetched slot is not yet visible in the RAM
  // output, so the head comes from the bypass copy for that one cycle.
  assign w_head = r_byp_vld ? r_byp_data : w_mem_q;

  ad_ip_jesd204_tpl_dac_fifo_mem #(
    .DATA_WIDTH (DMA_DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (dma_data),
    .i_rd_addr (w_rd_ptr_nxt),
    .o_rd_data (w_mem_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; enable low forces IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = FILL;
      FILL:    if (r_count >= c_prefill) w_state_nxt = ARMED;
      ARMED:   if (dac_sync) w_state_nxt = RUN;
      RUN:     if (w_uflow) w_state_nxt = FILL;
      default: w_state_nxt = IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = IDLE;
    end
  end

  // Pointers and occupancy; flushing discards everything on the next edge.
  always_ff @(posedge clk) begin
    if (!resetn || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture a write that targets the slot being prefetched this edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_byp_vld  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp_vld  <= w_wr & ~w_flush & (r_wr_ptr == w_rd_ptr_nxt);
      r_byp_data <= dma_data;
    end
  end

  // Output beat: head word on read, zero on underflow or outside RUN,
  // otherwise hold.
  always_ff @(posedge clk) begin
    if (!resetn || w_flush) begin
      r_dac_ddata <= '0;
    end else if (r_state == RUN) begin
      if (w_rd) begin
        r_dac_ddata <= w_head;
      end else if (w_uflow) begin
        r_dac_ddata <= '0;
      end
    end else begin
      r_dac_ddata <= '0;
    end
  end

  // Sticky underflow; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_underflow <= 1'b0;
    end else if (w_uflow) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end

  assign dac_ddata = r_dac_ddata;
  assign underflow = r_underflow;
  assign running   = (r_state == RUN);

`ifdef TPL_DAC_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] r_peak;

  // High-water mark of the registered occupancy.
  always_ff @(posedge clk) begin
    if (!resetn || underflow_clr) begin
      r_peak <= '0;
    end else if (r_count > r_peak) begin
      r_peak <= r_count;
    end
  end

  assign fifo_level = r_count;
  assign fifo_peak  = r_peak;
`else
  // Level and peak monitoring not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_ip_jesd204_tpl_dac_dma_fifo
// Description : Directed self-checking bench for the TPL DAC DMA FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_ip_jesd204_tpl_dac_dma_fifo;

  logic         clk;
  logic         resetn;
  logic         enable;
  logic         dma_valid;
  logic         dma_ready;
  logic [127:0] dma_data;
  logic         dac_valid;
  logic         dac_sync;
  logic [127:0] dac_ddata;
  logic         underflow;
  logic         underflow_clr;
  logic         running;

  int n_cmp = 0;
  int n_err = 0;

  ad_ip_jesd204_tpl_dac_dma_fifo #(
    .DMA_DATA_WIDTH (128),
    .ADDR_WIDTH     (4),
    .PREFILL_LEVEL  (8)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .dma_valid     (dma_valid),
    .dma_ready     (dma_ready),
    .dma_data      (dma_data),
    .dac_valid     (dac_valid),
    .dac_sync      (dac_sync),
    .dac_ddata     (dac_ddata),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .running       (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation still running after time limit");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [127:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      dma_valid = 1'b1;
      dma_data  = base + 128'(i);
      tick();
    end
    dma_valid = 1'b0;
  endtask

  // FILL -> ARMED on the first edge, then a sync pulse into RUN.
  task automatic arm_start();
    tick();
    chk("armed_not_running", {127'd0, running}, 128'd0);
    dac_sync = 1'b1;
    tick();
    dac_sync = 1'b0;
    chk("running_after_sync", {127'd0, running}, 128'd1);
    chk("ddata_zero_at_start", dac_ddata, 128'd0);
  endtask

  task automatic read_chk(input logic [127:0] base, input int n);
    dac_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("read_data", dac_ddata, base + 128'(i));
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; dma_valid = 1'b0; dma_data = '0;
    dac_valid = 1'b0; dac_sync = 1'b0; underflow_clr = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("rst_dma_ready", {127'd0, dma_ready}, 128'd0);
    chk("rst_running",   {127'd0, running},   128'd0);
    chk("rst_underflow", {127'd0, underflow}, 128'd0);
    chk("rst_ddata",     dac_ddata,           128'd0);

    // Prefill 1..8, start, read back with 1-cycle latency, then underflow.
    enable = 1'b1;
    tick();
    fill(128'h1, 8);
    arm_start();
    read_chk(128'h1, 8);
    tick();
    chk("uf1_ddata",   dac_ddata,           128'd0);
    chk("uf1_flag",    {127'd0, underflow}, 128'd1);
    chk("uf1_running", {127'd0, running},   128'd0);
    dac_valid = 1'b0; underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("uf1_cleared", {127'd0, underflow}, 128'd0);

    // Full: 16 accepts, 17th refused, exactly 16 words drain.
    for (int i = 0; i < 16; i++) begin
      chk("full_ready_before", {127'd0, dma_ready}, 128'd1);
      dma_valid = 1'b1;
      dma_data  = 128'h100 + 128'(i);
      tick();
    end
    chk("full_ready_low", {127'd0, dma_ready}, 128'd0);
    dma_data = 128'hDEAD;
    tick();
    chk("full_ready_still_low", {127'd0, dma_ready}, 128'd0);
    dma_valid = 1'b0;
    dac_sync = 1'b1;
    tick();
    dac_sync = 1'b0;
    chk("full_running", {127'd0, running}, 128'd1);
    read_chk(128'h100, 16);
    chk("full_ready_after_drain", {127'd0, dma_ready}, 128'd1);
    // Underflow edge coinciding with a clear: set wins.
    underflow_clr = 1'b1;
    tick();
    chk("uf_set_wins", {127'd0, underflow}, 128'd1);
    chk("uf2_ddata", dac_ddata, 128'd0);
    dac_valid = 1'b0;
    tick();
    underflow_clr = 1'b0;
    chk("uf_clr_next", {127'd0, underflow}, 128'd0);

    // Simultaneous read and write at count 5 for 100 cycles across wrap.
    fill(128'h200, 8);
    arm_start();
    read_chk(128'h200, 3);
    for (int j = 0; j < 100; j++) begin
      dma_valid = 1'b1;
      dma_data  = 128'h300 + 128'(j);
      tick();
      if (j < 5) chk("simul_data", dac_ddata, 128'h203 + 128'(j));
      else       chk("simul_data", dac_ddata, 128'h300 + 128'(j - 5));
    end
    dma_valid = 1'b0;
    read_chk(128'h300 + 128'd95, 5);
    tick();
    chk("simul_underflow", {127'd0, underflow}, 128'd1);
    dac_valid = 1'b0; underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;

    // Abort mid-RUN at count 10, then refill with new data only.
    fill(128'h400, 12);
    arm_start();
    read_chk(128'h400, 2);
    dac_valid = 1'b0; enable = 1'b0;
    tick();
    chk("abort_ddata",   dac_ddata,           128'd0);
    chk("abort_running", {127'd0, running},   128'd0);
    chk("abort_ready",   {127'd0, dma_ready}, 128'd0);
    enable = 1'b1;
    tick();
    fill(128'h500, 8);
    arm_start();
    read_chk(128'h500, 8);
    tick();
    chk("refill_underflow", {127'd0, underflow}, 128'd1);
    dac_valid = 1'b0;

    // Sync ignored in FILL and on the threshold edge; then reset mid-RUN.
    fill(128'h600, 7);
    dma_valid = 1'b1; dma_data = 128'h607; dac_sync = 1'b1;
    tick();
    dma_valid = 1'b0;
    tick();
    dac_sync = 1'b0;
    tick();
    chk("sync_ignored", {127'd0, running}, 128'd0);
    dac_sync = 1'b1;
    tick();
    dac_sync = 1'b0;
    chk("sync_armed", {127'd0, running}, 128'd1);
    read_chk(128'h600, 3);
    dac_valid = 1'b0; resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mrst_ddata",     dac_ddata,           128'd0);
    chk("mrst_running",   {127'd0, running},   128'd0);
    chk("mrst_underflow", {127'd0, underflow}, 128'd0);
    chk("mrst_ready",     {127'd0, dma_ready}, 128'd1);
    tick();
    fill(128'h700, 8);
    arm_start();
    read_chk(128'h700, 1);
    dac_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
